// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root job wrapper: FSM encoding and default sizing.
// Latency and backpressure are not applicable here; the package holds declarations only.
package sqrt_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] PUSH  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_WAIT  = WAIT,
    S_PUSH  = PUSH
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_RWIDTH  = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/sqrt_result_fifo.sv
// Synchronous result FIFO; head is shown combinationally, so a push is visible the next cycle.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module sqrt_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_dat_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/sqrt_job_wrapper.sv
// Launches one square-root job per accepted operand and queues {operand, root} results; optional SQRT_WATCHDOG_EN flags hung jobs.
// Result visible one cycle after the core's armed done; input stalls while a job is in flight or the result FIFO is full.
module sqrt_job_wrapper
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RWIDTH  = DEF_RWIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_operand_i,
  output logic              core_start_o,
  output logic [WIDTH-1:0]  core_operand_o,
  input  logic              core_ready_i,
  input  logic [RWIDTH-1:0] core_root_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_operand_o,
  output logic [RWIDTH-1:0] out_root_o,
  output logic              out_err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SQRT_WATCHDOG_EN
  localparam int unsigned ENTRY_W = WIDTH + RWIDTH + 1;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_err;
`else
  localparam int unsigned ENTRY_W = WIDTH + RWIDTH;
`endif

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    operand_q, operand_d;
  logic                armed_q, armed_d;
  logic                push;
  logic [RWIDTH-1:0]   push_root;
  logic [ENTRY_W-1:0]  push_dat, head_dat;
  logic [AW:0]         fifo_count;
  logic                fifo_full, fifo_empty;
  logic                accept;

  assign in_ready_o     = (state_q == S_IDLE) && (fifo_count != (AW+1)'(DEPTH));
  assign accept         = in_valid_i && in_ready_o;
  assign core_operand_o = operand_q;
  assign out_valid_o    = !fifo_empty;

  always_comb begin
    state_d      = state_q;
    operand_d    = operand_q;
    armed_d      = armed_q;
    core_start_o = 1'b0;
    push         = 1'b0;
    push_root    = core_root_i;
`ifdef SQRT_WATCHDOG_EN
    cnt_d        = cnt_q;
    push_err     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          operand_d = in_operand_i;
          state_d   = S_START;
        end
      end
      S_START: begin
        core_start_o = 1'b1;
        armed_d      = 1'b0;
`ifdef SQRT_WATCHDOG_EN
        cnt_d        = '0;
`endif
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A low ready before the core has been seen busy is the previous job's parked done.
        if (core_ready_i) armed_d = 1'b1;
        if (armed_q && !core_ready_i) begin
          push    = !fifo_full;
          state_d = S_PUSH;
        end
`ifdef SQRT_WATCHDOG_EN
        else if (cnt_q == CNT_LAST) begin
          push      = !fifo_full;
          push_root = '0;
          push_err  = 1'b1;
          state_d   = S_PUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      armed_q   <= 1'b0;
`ifdef SQRT_WATCHDOG_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      armed_q   <= armed_d;
`ifdef SQRT_WATCHDOG_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

`ifdef SQRT_WATCHDOG_EN
  assign push_dat = {push_err, operand_q, push_root};
  assign out_err_o = head_dat[ENTRY_W-1];
`else
  assign push_dat = {operand_q, push_root};
  assign out_err_o = 1'b0;
`endif
  assign out_operand_o = head_dat[WIDTH+RWIDTH-1:RWIDTH];
  assign out_root_o    = head_dat[RWIDTH-1:0];

  sqrt_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (out_ready_i),
    .pop_dat_o  (head_dat),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_sqrt_job_wrapper.sv
// Bench for sqrt_job_wrapper: behavioural floor-sqrt core with programmable latency, table vectors,
// hand-written corner sequences and a randomized run checked against a queue-based reference.
module tb_sqrt_job_wrapper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready_o;
  logic [7:0] in_operand = '0;
  logic       core_start_o;
  logic [7:0] core_operand_o;
  logic       core_ready;
  logic [7:0] core_root;
  logic       out_valid_o;
  logic       out_ready = 1'b0;
  logic [7:0] out_operand_o;
  logic [7:0] out_root_o;
  logic       out_err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_job_wrapper #(.WIDTH(8), .RWIDTH(8), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready_o),
    .in_operand_i   (in_operand),
    .core_start_o   (core_start_o),
    .core_operand_o (core_operand_o),
    .core_ready_i   (core_ready),
    .core_root_i    (core_root),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .out_operand_o  (out_operand_o),
    .out_root_o     (out_root_o),
    .out_err_o      (out_err_o)
  );

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Core model: ready spans a load cycle, lat compute cycles and a writeback cycle;
  // stale holds the previous parked done low for a few cycles after start; hang never finishes.
  int       lat = 6;
  int       stale = 0;
  bit       hang = 1'b0;
  bit       rand_lat = 1'b0;
  int       busy_q = 0;
  int       dly_q = 0;
  logic [7:0] c_pend = '0;
  logic [7:0] c_root_q = '0;

  always @(posedge clk) begin
    if (core_start_o) begin
      c_pend <= 8'(isqrt(int'(core_operand_o)));
      dly_q  <= stale;
      busy_q <= (rand_lat ? int'($urandom_range(0, 8)) : lat) + 2;
    end else if (dly_q != 0) begin
      dly_q <= dly_q - 1;
    end else if (busy_q != 0 && !hang) begin
      busy_q <= busy_q - 1;
      if (busy_q == 1) c_root_q <= c_pend;
    end
  end
  assign core_ready = (dly_q == 0) && (busy_q != 0);
  assign core_root  = c_root_q;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic offer(input int op);
    int t = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_operand = 8'(op);
    #1;
    while (!in_ready_o && t < 300) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready_o) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input int op, input int root, input int err);
    int t = 0;
    @(negedge clk); #1;
    while (!out_valid_o && t < 300) begin
      @(negedge clk); #1; t++;
    end
    if (!out_valid_o) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_operand"}, int'(out_operand_o), op);
    chk({nm, "_root"}, int'(out_root_o), root);
    chk({nm, "_err"}, int'(out_err_o), err);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct { int op; int root; } vec_t;
  typedef struct { int op; int root; int err; } exp_t;

  initial begin : main
    vec_t vecs[12];
    exp_t exp_q[$];
    exp_t e;
    int   k, t, sent;
    bit   flag, hold;

    vecs = '{'{16, 4}, '{0, 0}, '{1, 1}, '{255, 15}, '{100, 10}, '{81, 9},
             '{2, 1}, '{3, 1}, '{4, 2}, '{15, 3}, '{224, 14}, '{225, 15}};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_core_start", core_start_o, 0);
    chk("rst_core_operand", core_operand_o, 0);
    chk("rst_out_err", out_err_o, 0);

    // Single job 16, L=6: start pulse right after acceptance, entry 10 cycles after acceptance
    @(negedge clk);
    in_valid = 1'b1; in_operand = 8'd16;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("start_pulse_on", core_start_o, 1);
    chk("core_operand_latched", core_operand_o, 16);
    k = 0;
    while (!out_valid_o && k < 50) begin
      @(posedge clk); #1; k++;
      if (k == 1) chk("start_pulse_off", core_start_o, 0);
    end
    chk("latency_16", k, 10);
    chk("core_operand_stable", core_operand_o, 16);
    pop_expect("job16", 16, 4, 0);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      offer(vecs[i].op);
      pop_expect($sformatf("vec%0d", i), vecs[i].op, vecs[i].root, 0);
    end

    // Fill to DEPTH with no consumer; fifth offer must stall until one pop
    foreach (vecs[i]) if (i >= 1 && i <= 4) offer(vecs[i].op);
    flag = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      if (in_ready_o) flag = 1'b0;
    end
    chk("full_in_ready_low", flag, 1);
    @(negedge clk);
    in_valid = 1'b1; in_operand = 8'd49;
    flag = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      if (in_ready_o) flag = 1'b0;
    end
    chk("fifth_offer_stalled", flag, 1);
    pop_expect("q0", 0, 0, 0);
    offer(49);
    pop_expect("q1", 1, 1, 0);
    pop_expect("q2", 255, 15, 0);
    pop_expect("q3", 100, 10, 0);
    pop_expect("q4", 49, 7, 0);

    // Stale low done at start and late ready rise: entry must carry the new root
    stale = 2;
    offer(144);
    pop_expect("stale", 144, 12, 0);
    stale = 0;

    // Simultaneous push and pop with two entries queued
    offer(4);
    offer(9);
    repeat (15) @(negedge clk);
    offer(25);
    t = 0;
    #1;
    while (!core_ready && t < 100) begin @(negedge clk); #1; t++; end
    while (core_ready && t < 100) begin @(negedge clk); #1; t++; end
    chk("simul_core_done_seen", t < 100, 1);
    chk("simul_head", out_operand_o, 4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pop_expect("simul_a", 9, 3, 0);
    pop_expect("simul_b", 25, 5, 0);
    @(negedge clk); #1;
    chk("simul_drained", out_valid_o, 0);

    // Reset mid-job: the in-flight operand must never appear
    offer(81);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_in_ready", in_ready_o, 1);
    chk("midrst_core_operand", core_operand_o, 0);
    flag = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (out_valid_o) flag = 1'b0;
    end
    chk("midrst_no_entry", flag, 1);
    offer(9);
    pop_expect("after_rst", 9, 3, 0);

`ifdef SQRT_WATCHDOG_EN
    // Hung core: error entry after TIMEOUT wait cycles, then a normal job
    hang = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_operand = 8'd50;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid_o && k < 100) begin @(posedge clk); #1; k++; end
    chk("wdog_latency", k, 21);
    pop_expect("wdog", 50, 0, 1);
    hang = 1'b0;
    offer(36);
    pop_expect("wdog_next", 36, 6, 0);
`endif

    // Randomized traffic against the queue reference
    rand_lat = 1'b1;
    sent = 0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 4000 && (sent < 40 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid   = (sent < 40) && ($urandom_range(0, 3) != 0);
        in_operand = 8'($urandom_range(0, 255));
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready_o) begin
        exp_q.push_back('{int'(in_operand), isqrt(int'(in_operand)), 0});
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      if (out_valid_o && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_entry", int'(out_operand_o), -1);
        end else begin
          e = exp_q.pop_front();
          chk("rand_operand", int'(out_operand_o), e.op);
          chk("rand_root", int'(out_root_o), e.root);
          chk("rand_err", int'(out_err_o), e.err);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_jobs_sent", sent, 40);
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : global_timeout
    #3_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
